// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive paths.
// UART_TX_ODD_PARITY_EN selects odd parity in place of the default even parity.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } UART_TX_STATE_e;

    function automatic logic tx_parity(input logic [UART_DATA_W-1:0] data);
`ifdef UART_TX_ODD_PARITY_EN
        return ~^data;
`else
        return ^data;
`endif
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte interface of the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    // tx_start is a level request: it is taken on an edge where the
    // transmitter is idle, or where tx_done is high (back-to-back frames).
    // tx_data is only looked at on that edge; at any other time tx_start is ignored.
    logic                   tx_start;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_busy;
    logic                   tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..BIT_CYCLES-1 while enabled, flags the last cycle.
module uart_baud_cnt #(
    parameter int BIT_CYCLES = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || !enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_end = enable && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop.
// Defining UART_TX_ODD_PARITY_EN switches the parity bit to odd parity.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 434,
    parameter int DATA_W     = UART_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_if.slave       host,
    output logic           tx,
    output UART_TX_STATE_e state
);

    localparam int IW = $clog2(DATA_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    UART_TX_STATE_e    state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              tx_q, tx_d;
    logic              bit_end;
    logic              accept;

    uart_baud_cnt #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q != TX_IDLE),
        .clear  (accept),
        .bit_end(bit_end)
    );

    // Accepting in the final STOP cycle lets frames run back to back.
    assign accept = host.tx_start &&
                    ((state_q == TX_IDLE) || (state_q == TX_STOP && bit_end));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= TX_IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:   if (accept) state_d = TX_START;
            TX_START:  if (bit_end) state_d = TX_DATA;
            TX_DATA:   if (bit_end && idx_q == LAST_IDX) state_d = TX_PARITY;
            TX_PARITY: if (bit_end) state_d = TX_STOP;
            TX_STOP:   if (bit_end) state_d = accept ? TX_START : TX_IDLE;
            default:   state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        shift_d  = shift_q;
        parity_d = parity_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        if (accept) begin
            shift_d  = host.tx_data;
            parity_d = tx_parity(host.tx_data);
            idx_d    = '0;
            tx_d     = 1'b0;
        end else if (bit_end) begin
            case (state_q)
                TX_START: begin
                    tx_d  = shift_q[0];
                    idx_d = '0;
                end
                TX_DATA: begin
                    if (idx_q == LAST_IDX) begin
                        tx_d = parity_q;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + IW'(1);
                    end
                end
                default: tx_d = 1'b1;
            endcase
        end
    end

    assign host.tx_busy = (state_q != TX_IDLE);
    assign host.tx_done = (state_q == TX_STOP) && bit_end;
    assign tx           = tx_q;
    assign state        = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clk cycles per bit.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int BC        = 4;
    localparam int FRAME_CYC = BC * UART_FRAME_BITS;

    logic           clk;
    logic           rst;
    logic           tx;
    UART_TX_STATE_e state;
    int             total;
    int             bad;

    uart_tx_if bus ();

    uart_tx #(
        .BIT_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .host (bus),
        .tx   (tx),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frames are written for even parity; odd parity only flips frame bit 9.
    function automatic logic [10:0] fix(input logic [10:0] f);
`ifdef UART_TX_ODD_PARITY_EN
        return f ^ 11'h200;
`else
        return f;
`endif
    endfunction

    task automatic launch(input logic [7:0] data, input bit hold);
        @(negedge clk);
        bus.tx_start = 1'b1;
        bus.tx_data  = data;
        @(posedge clk);
        #1;
        if (!hold) bus.tx_start = 1'b0;
    endtask

    task automatic check_idle(input string name);
        total++;
        if (tx !== 1'b1) begin
            bad++;
            $display("FAIL %s tx got %b want 1", name, tx);
        end
        total++;
        if (bus.tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy got %b want 0", name, bus.tx_busy);
        end
        total++;
        if (bus.tx_done !== 1'b0) begin
            bad++;
            $display("FAIL %s done got %b want 0", name, bus.tx_done);
        end
        total++;
        if (state !== TX_IDLE) begin
            bad++;
            $display("FAIL %s state got %0d want %0d", name, state, TX_IDLE);
        end
    endtask

    // Samples every cycle after the accept edge; frame bit i lives in bit i.
    task automatic check_stream(input string name, input logic [10:0] f0,
                                input logic [10:0] f1, input int nf, input int pulse_at);
        logic [10:0] cur;
        int          bi;
        logic        exp_tx;
        logic        exp_done;
        for (int k = 0; k < nf * FRAME_CYC; k++) begin
            @(negedge clk);
            cur      = (k < FRAME_CYC) ? f0 : f1;
            bi       = (k % FRAME_CYC) / BC;
            exp_tx   = cur[bi];
            exp_done = ((k % FRAME_CYC) == FRAME_CYC - 1);
            total++;
            if (tx !== exp_tx) begin
                bad++;
                $display("FAIL %s tx k=%0d got %b want %b", name, k, tx, exp_tx);
            end
            total++;
            if (bus.tx_done !== exp_done) begin
                bad++;
                $display("FAIL %s done k=%0d got %b want %b", name, k, bus.tx_done, exp_done);
            end
            total++;
            if (bus.tx_busy !== 1'b1) begin
                bad++;
                $display("FAIL %s busy k=%0d got %b want 1", name, k, bus.tx_busy);
            end
            if (pulse_at >= 0 && k == pulse_at) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'h3C;
            end else if (pulse_at >= 0 && k == pulse_at + 1) begin
                bus.tx_start = 1'b0;
            end
            if (k == nf * FRAME_CYC - 1) bus.tx_start = 1'b0;
        end
        @(negedge clk);
        check_idle({name, "_end"});
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_single();
        launch(8'h55, 1'b0);
        check_stream("single_55", fix(11'h4AA), 11'h000, 1, -1);
    endtask

    task automatic test_parity();
        launch(8'h07, 1'b0);
        check_stream("parity_07", fix(11'h60E), 11'h000, 1, -1);
        launch(8'h00, 1'b0);
        check_stream("parity_00", fix(11'h400), 11'h000, 1, -1);
    endtask

    task automatic test_busy_ignore();
        launch(8'hA5, 1'b0);
        check_stream("busy_ignore", fix(11'h54A), 11'h000, 1, 20);
    endtask

    task automatic test_back_to_back();
        launch(8'hF0, 1'b1);
        bus.tx_data = 8'h0F;
        check_stream("back_to_back", fix(11'h5E0), fix(11'h41E), 2, -1);
    endtask

    task automatic test_reset_mid_frame();
        launch(8'hFF, 1'b0);
        repeat (14) @(negedge clk);
        total++;
        if (state !== TX_DATA) begin
            bad++;
            $display("FAIL mid_state got %0d want %0d", state, TX_DATA);
        end
        #2 rst = 1'b0;
        #1;
        check_idle("reset_mid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_release");
        launch(8'h81, 1'b0);
        check_stream("after_reset_81", fix(11'h502), 11'h000, 1, -1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_parity();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
